// File: rtl/cgra_pe_pkg.sv
// Shared types for the CGRA processing-element tile.
// Optional MAC/CLRACC support is enabled by defining CGRA_PE_MAC_EN.
package cgra_pe_pkg;

  typedef enum logic [4:0] {
    OP_NOP    = 5'd0,
    OP_ADD    = 5'd1,
    OP_SUB    = 5'd2,
    OP_MUL    = 5'd3,
    OP_AND    = 5'd4,
    OP_OR     = 5'd5,
    OP_XOR    = 5'd6,
    OP_SHL    = 5'd7,
    OP_SHR    = 5'd8,
    OP_SRA    = 5'd9,
    OP_SLT    = 5'd10,
    OP_MIN    = 5'd11,
    OP_MAX    = 5'd12,
    OP_PASS   = 5'd13,
    OP_MAC    = 5'd14,
    OP_CLRACC = 5'd15
  } opcode_e;

  localparam logic [4:0] SRC_NBR0 = 5'd16;
  localparam logic [4:0] SRC_MEM  = 5'd24;
  localparam logic [4:0] SRC_ZERO = 5'd31;

  typedef struct packed {
    logic [31:0] imm;
    logic [4:0]  opcode;
    logic        b_imm;
    logic [4:0]  src_a;
    logic [4:0]  src_b;
    logic [2:0]  dst;
    logic        wr_rf;
    logic        wr_mem;
    logic        wr_out;
    logic [7:0]  nbr_mask;
    logic        rsvd;
    logic        valid;
  } instr_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/cgra_pe_alu.sv
// Combinational ALU of the CGRA tile.
// MAC/CLRACC exist only when CGRA_PE_MAC_EN is defined.
module cgra_pe_alu
  import cgra_pe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [4:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
`ifdef CGRA_PE_MAC_EN
  input  logic [DATA_W-1:0] acc_i,
`endif
  output logic [DATA_W-1:0] res_o,
  output logic              ill_o
);

  localparam int SHW = $clog2(DATA_W);

  logic [SHW-1:0] sh;
  logic           lt;

  assign sh = b_i[SHW-1:0];
  assign lt = $signed(a_i) < $signed(b_i);

  always_comb begin
    res_o = '0;
    ill_o = 1'b0;
    unique case (op_i)
      OP_NOP:  res_o = '0;
      OP_ADD:  res_o = a_i + b_i;
      OP_SUB:  res_o = a_i - b_i;
      OP_MUL:  res_o = a_i * b_i;
      OP_AND:  res_o = a_i & b_i;
      OP_OR:   res_o = a_i | b_i;
      OP_XOR:  res_o = a_i ^ b_i;
      OP_SHL:  res_o = a_i << sh;
      OP_SHR:  res_o = a_i >> sh;
      OP_SRA:  res_o = $unsigned($signed(a_i) >>> sh);
      OP_SLT:  res_o = DATA_W'(lt);
      OP_MIN:  res_o = lt ? a_i : b_i;
      OP_MAX:  res_o = lt ? b_i : a_i;
      OP_PASS: res_o = a_i;
`ifdef CGRA_PE_MAC_EN
      OP_MAC:    res_o = acc_i + a_i * b_i;
      OP_CLRACC: res_o = '0;
`endif
      default: ill_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/cgra_pe_tile.sv
// One CGRA processing element: instruction FSM, RF, handshakes.
// Define CGRA_PE_MAC_EN to add the accumulator (MAC/CLRACC).
module cgra_pe_tile
  import cgra_pe_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_NBR  = 8,
  parameter int RF_DEPTH = 8,
  parameter int MEM_AW   = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [63:0]               instruction,
  output logic                      instr_ready,
  input  logic [DATA_W-1:0]         mem_rd_data,
  input  logic                      mem_rd_valid,
  output logic                      mem_rd_ready,
  output logic [DATA_W-1:0]         mem_wr_data,
  output logic [MEM_AW-1:0]         mem_wr_addr,
  output logic                      mem_wr_en,
  input  logic [NUM_NBR*DATA_W-1:0] nbr_in_data,
  input  logic [NUM_NBR-1:0]        nbr_in_valid,
  output logic [NUM_NBR-1:0]        nbr_in_ready,
  output logic [NUM_NBR*DATA_W-1:0] nbr_out_data,
  output logic [NUM_NBR-1:0]        nbr_out_valid,
  input  logic [NUM_NBR-1:0]        nbr_out_ready,
  output logic [DATA_W-1:0]         final_output,
  output logic                      final_valid,
  output logic                      illegal_err
);

  localparam logic [4:0] RF_LIM  = 5'(RF_DEPTH);
  localparam logic [3:0] NBR_LIM = 4'(NUM_NBR);

  state_e                      state_q, state_d;
  instr_t                      ins_q;
  logic [DATA_W-1:0]           rf_q [RF_DEPTH];
  logic [NUM_NBR*DATA_W-1:0]   nbr_data_q;
  logic [NUM_NBR-1:0]          nbr_vld_q;
  logic [DATA_W-1:0]           wdata_q, fin_q;
  logic [MEM_AW-1:0]           waddr_q;
  logic                        wen_q, fvld_q, ill_q;

  logic [DATA_W-1:0]  imm, alu_res;
  logic [DATA_W-1:0]  opv [2];
  logic [4:0]         code [2];
  logic [1:0]         src_ok, src_ill;
  logic [NUM_NBR-1:0] nbr_use, mask_eff;
  logic               mem_use, alu_ill, dst_ok, fire, do_wr, ld;
  logic               unused_bits;

  assign imm = DATA_W'($signed(ins_q.imm));
  assign unused_bits = ^{ins_q.rsvd, ins_q.valid};

  // Source decode: out-of-range codes read zero and never stall.
  always_comb begin
    code[0] = ins_q.src_a;
    code[1] = ins_q.src_b;
    nbr_use = '0;
    mem_use = 1'b0;
    src_ok  = 2'b11;
    src_ill = 2'b00;
    for (int s = 0; s < 2; s++) begin
      opv[s] = '0;
      if (s == 1 && ins_q.b_imm) begin
        opv[s] = imm;
      end else if (code[s] < SRC_NBR0) begin
        if (code[s] < RF_LIM) opv[s] = rf_q[code[s][2:0]];
        else src_ill[s] = 1'b1;
      end else if (code[s] < SRC_MEM) begin
        if ({1'b0, code[s][2:0]} < NBR_LIM) begin
          opv[s] = nbr_in_data[DATA_W*int'(code[s][2:0]) +: DATA_W];
          src_ok[s] = nbr_in_valid[code[s][2:0]];
          nbr_use[code[s][2:0]] = 1'b1;
        end else begin
          src_ill[s] = 1'b1;
        end
      end else if (code[s] == SRC_MEM) begin
        opv[s]    = mem_rd_data;
        src_ok[s] = mem_rd_valid;
        mem_use   = 1'b1;
      end else if (code[s] != SRC_ZERO) begin
        src_ill[s] = 1'b1;
      end
    end
  end

`ifdef CGRA_PE_MAC_EN
  logic [DATA_W-1:0] acc_q;
`endif

  cgra_pe_alu #(.DATA_W(DATA_W)) u_alu (
    .op_i  (ins_q.opcode),
    .a_i   (opv[0]),
    .b_i   (opv[1]),
`ifdef CGRA_PE_MAC_EN
    .acc_i (acc_q),
`endif
    .res_o (alu_res),
    .ill_o (alu_ill)
  );

  assign mask_eff = ins_q.nbr_mask[NUM_NBR-1:0] & {NUM_NBR{~alu_ill}};
  assign dst_ok   = &(~mask_eff | ~nbr_vld_q | nbr_out_ready);
  assign fire     = ~rst & (state_q == S_WAIT) & (&src_ok) & dst_ok;
  assign do_wr    = fire & ~alu_ill;
  assign ld       = instr_ready & instruction[0];

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instruction[0]) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (fire) begin
          instr_ready = 1'b1;
          state_d = instruction[0] ? S_WAIT : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ins_q   <= '0;
    end else begin
      state_q <= state_d;
      if (ld) ins_q <= instruction;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
    end else if (do_wr && ins_q.wr_rf && {2'b0, ins_q.dst} < RF_LIM) begin
      rf_q[ins_q.dst] <= alu_res;
    end
  end

  // A drain and a refill in the same cycle leave the channel valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      nbr_vld_q  <= '0;
      nbr_data_q <= '0;
    end else begin
      for (int i = 0; i < NUM_NBR; i++) begin
        if (fire && mask_eff[i]) begin
          nbr_vld_q[i] <= 1'b1;
          nbr_data_q[i*DATA_W +: DATA_W] <= alu_res;
        end else if (nbr_out_ready[i]) begin
          nbr_vld_q[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q   <= 1'b0;
      wdata_q <= '0;
      waddr_q <= '0;
      fvld_q  <= 1'b0;
      fin_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      wen_q  <= do_wr & ins_q.wr_mem;
      fvld_q <= do_wr & ins_q.wr_out;
      if (do_wr && ins_q.wr_mem) begin
        wdata_q <= alu_res;
        waddr_q <= ins_q.imm[MEM_AW-1:0];
      end
      if (do_wr && ins_q.wr_out) fin_q <= alu_res;
      if (fire && (alu_ill || |src_ill)) ill_q <= 1'b1;
    end
  end

`ifdef CGRA_PE_MAC_EN
  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else if (do_wr && ins_q.opcode == OP_MAC) acc_q <= alu_res;
    else if (do_wr && ins_q.opcode == OP_CLRACC) acc_q <= '0;
  end
`endif

  assign nbr_in_ready  = fire ? nbr_use : '0;
  assign mem_rd_ready  = fire & mem_use;
  assign mem_wr_en     = wen_q;
  assign mem_wr_data   = wdata_q;
  assign mem_wr_addr   = waddr_q;
  assign nbr_out_valid = nbr_vld_q;
  assign nbr_out_data  = nbr_data_q;
  assign final_output  = fin_q;
  assign final_valid   = fvld_q;
  assign illegal_err   = ill_q;

endmodule
